// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   WORD_W / word_t : instruction and word-address width (32 bits).
//   RESET_PC        : first fetch address after reset.
//   NOP             : word presented on inst while nothing is queued.
//   entry_t         : queue entry {pc, inst}.
//   CNT_W/cnt_width : width of a 0..DEPTH occupancy counter.
package fetch_pkg;

  localparam int WORD_W        = 32;
  localparam int DEPTH_DEFAULT = 4;

  localparam logic [WORD_W-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [WORD_W-1:0] NOP      = 32'h0000_0000;

  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t inst;
  } entry_t;

  // Counters must hold the value DEPTH itself, hence DEPTH+1 states.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int CNT_W = $clog2(DEPTH_DEFAULT + 1);

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous DEPTH-entry FIFO of {pc, inst} entries.
//   clk, srst   : clock, synchronous active-high reset.
//   flush_i     : empties the queue at the edge (wins over push/pop).
//   push_i      : write push_entry_i at the tail.
//   pop_i       : drop the head entry.
//   head_o      : head entry, combinational (valid only when !empty_o).
//   count_o     : occupancy 0..DEPTH.
//   full_o      : count_o == DEPTH.
//   empty_o     : count_o == 0.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             flush_i,
  input  logic             push_i,
  input  entry_t           push_entry_i,
  input  logic             pop_i,
  output entry_t           head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full queue is accepted only when the head leaves in the
  // same cycle, so the slot being written is the one just vacated.
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
      else if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

  // The upstream credit scheme must never push into a full, non-draining queue.
  always_ff @(posedge clk) begin
    if (!srst && !flush_i) assert (!(push_i && full_o && !pop_i));
  end

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: decoupled instruction-fetch stage.
//   clk, reset                     : clock, synchronous active-high reset.
//   imem_req_valid/ready/addr      : fetch request to instruction memory.
//   imem_rsp_valid/data            : in-order responses, latency >= 1 cycle.
//   redirect_valid/redirect_pc     : one-cycle PC redirect, flushes everything.
//   inst_valid/ready               : handshake towards decode.
//   inst, inst_pc, inst_pc_plus_1  : head instruction, its PC and PC+1.
// Fetch credit: queued + outstanding + to-be-dropped responses never exceed
// DEPTH, so every response that is kept always finds a free queue slot.
module ifetch_unit #(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [DATA_W-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [DATA_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [DATA_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [DATA_W-1:0] inst_pc,
  output logic [DATA_W-1:0] inst_pc_plus_1
);

  import fetch_pkg::*;

  localparam int QCNT_W = cnt_width(DEPTH);
  localparam int SUM_W  = QCNT_W + 2;

  logic [DATA_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [QCNT_W-1:0] outstanding_q, outstanding_d;
  logic [QCNT_W-1:0] drop_q, drop_d;

  logic [QCNT_W-1:0] q_count;
  logic              q_full, q_empty;
  entry_t            q_head, q_push_entry;
  logic              q_push, q_pop;

  logic [SUM_W-1:0]  in_use;
  logic              credit_ok, req_fire, rsp_keep, rsp_drop;
  logic [DATA_W-1:0] oldest_pc;

  // Credit comes only from registered state; a dequeue this cycle frees
  // its slot for issue on the next cycle.
  assign in_use    = SUM_W'(q_count) + SUM_W'(outstanding_q) + SUM_W'(drop_q);
  assign credit_ok = (in_use < SUM_W'(DEPTH)) && !q_full;

  assign imem_req_valid = !reset && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (drop_q != '0);
  assign rsp_keep = imem_rsp_valid && (drop_q == '0);

  // Responses return in order, so the oldest outstanding request's PC is
  // fetch_pc minus the number still in flight.
  assign oldest_pc         = fetch_pc_q - DATA_W'(outstanding_q);
  assign q_push_entry.pc   = oldest_pc;
  assign q_push_entry.inst = imem_rsp_data;
  assign q_push            = rsp_keep && !redirect_valid && !reset;

  assign inst_valid     = !reset && !q_empty && !redirect_valid;
  assign q_pop          = inst_valid && inst_ready;
  assign inst           = q_empty ? NOP : q_head.inst;
  assign inst_pc        = q_head.pc;
  assign inst_pc_plus_1 = q_head.pc + DATA_W'(1);

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    if (redirect_valid) begin
      // Everything still in flight becomes garbage; a response landing this
      // cycle is discarded now and therefore not counted again.
      fetch_pc_d    = redirect_pc;
      outstanding_d = '0;
      drop_d        = drop_q + outstanding_q - QCNT_W'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + DATA_W'(1);
      outstanding_d = outstanding_q + QCNT_W'(req_fire) - QCNT_W'(rsp_keep);
      drop_d        = drop_q - QCNT_W'(rsp_drop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .CNT_W (QCNT_W)
  ) u_queue (
    .clk          (clk),
    .srst         (reset),
    .flush_i      (redirect_valid),
    .push_i       (q_push),
    .push_entry_i (q_push_entry),
    .pop_i        (q_pop),
    .head_o       (q_head),
    .count_o      (q_count),
    .full_o       (q_full),
    .empty_o      (q_empty)
  );

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed bench for ifetch_unit with an in-order
// instruction-memory model whose data word is the bitwise inverse of the address.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus_1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ifetch_unit #(
    .DATA_W   (32),
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_pc_plus_1 (inst_pc_plus_1)
  );

  // ---------------- instruction memory model ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  int          lat = 1;
  int          edge_no = 0;
  int          n_fire = 0;
  logic [31:0] last_addr = 32'h0;
  logic        mem_f, mem_r;
  logic [31:0] mem_a;

  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      mem_f = imem_req_valid && imem_req_ready;
      mem_a = imem_req_addr;
      mem_r = reset;
      @(posedge clk);
      #1;
      edge_no++;
      if (mem_r) begin
        pend.delete();
      end else if (mem_f) begin
        pend.push_back('{addr: mem_a, due: edge_no + lat - 1});
        n_fire++;
        last_addr = mem_a;
      end
      if (!mem_r && pend.size() > 0 && pend[0].due <= edge_no) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = ~pend[0].addr;
        void'(pend.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
      else begin
        errors++;
        $error("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
  endtask

  int base;

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1; imem_req_ready = 1'b1; redirect_valid = 1'b0;
    redirect_pc = 32'h0; inst_ready = 1'b1; lat = 1;
    repeat (3) step();
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);

    // Streaming at latency 1: first instruction two cycles after release.
    step(); reset = 1'b0; #1;
    chk("t1_c0_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t1_c0_addr", imem_req_addr, 32'd0);
    chk("t1_c0_inst_valid", 32'(inst_valid), 32'd0);
    step(); #1;
    chk("t1_c1_inst_valid", 32'(inst_valid), 32'd0);
    chk("t1_c1_addr", imem_req_addr, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(); #1;
      chk($sformatf("t1_valid_%0d", i), 32'(inst_valid), 32'd1);
      chk($sformatf("t1_pc_%0d", i), inst_pc, 32'(i));
      chk($sformatf("t1_inst_%0d", i), inst, ~32'(i));
      chk($sformatf("t1_pc1_%0d", i), inst_pc_plus_1, 32'(i + 1));
    end

    // Decode stalled: exactly DEPTH requests, then backpressure.
    reset = 1'b1; inst_ready = 1'b0;
    step(); step();
    base = n_fire;
    reset = 1'b0;
    repeat (10) step();
    #1;
    chk("t2_fire_count", 32'(n_fire - base), 32'd4);
    chk("t2_last_addr", last_addr, 32'd3);
    chk("t2_req_valid_full", 32'(imem_req_valid), 32'd0);
    chk("t2_inst_valid", 32'(inst_valid), 32'd1);
    chk("t2_head_pc", inst_pc, 32'd0);
    inst_ready = 1'b1; #1;
    chk("t2_r0_req_valid", 32'(imem_req_valid), 32'd0);
    step(); #1;
    chk("t2_r1_pc", inst_pc, 32'd1);
    chk("t2_r1_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t2_r1_addr", imem_req_addr, 32'd4);
    step(); #1;
    chk("t2_r2_pc", inst_pc, 32'd2);
    step(); #1;
    chk("t2_r3_pc", inst_pc, 32'd3);
    step(); #1;
    chk("t2_r4_pc", inst_pc, 32'd4);
    chk("t2_r4_inst", inst, ~32'd4);

    // Latency 3, redirect while the response for 5 arrives.
    reset = 1'b1; lat = 3;
    step(); step();
    reset = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'd5; #1;
    chk("t3_c0_req_valid", 32'(imem_req_valid), 32'd0);
    step(); redirect_valid = 1'b0; #1;
    chk("t3_c1_addr", imem_req_addr, 32'd5);
    step(); #1;
    chk("t3_c2_addr", imem_req_addr, 32'd6);
    step(); #1;
    chk("t3_c3_addr", imem_req_addr, 32'd7);
    step(); redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
    chk("t3_c4_req_withdrawn", 32'(imem_req_valid), 32'd0);
    chk("t3_c4_inst_valid", 32'(inst_valid), 32'd0);
    step(); redirect_valid = 1'b0; #1;
    chk("t3_c5_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t3_c5_addr", imem_req_addr, 32'h40);
    for (int c = 5; c <= 8; c++) begin
      chk($sformatf("t3_c%0d_no_stale", c), 32'(inst_valid), 32'd0);
      step(); #1;
    end
    chk("t3_c9_valid", 32'(inst_valid), 32'd1);
    chk("t3_c9_pc", inst_pc, 32'h40);
    chk("t3_c9_inst", inst, ~32'h40);

    // Redirect while a request is stalled on req_ready.
    reset = 1'b1; lat = 1; imem_req_ready = 1'b0;
    step(); step();
    reset = 1'b0; #1;
    base = n_fire;
    chk("t4_c0_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t4_c0_addr", imem_req_addr, 32'd0);
    step(); #1;
    chk("t4_c1_addr_held", imem_req_addr, 32'd0);
    step(); redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
    chk("t4_c2_withdrawn", 32'(imem_req_valid), 32'd0);
    step(); redirect_valid = 1'b0; imem_req_ready = 1'b1; #1;
    chk("t4_c3_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t4_c3_addr", imem_req_addr, 32'h100);
    chk("t4_c3_no_fire", 32'(n_fire - base), 32'd0);
    chk("t4_c3_inst_valid", 32'(inst_valid), 32'd0);
    step(); #1;
    chk("t4_c4_inst_valid", 32'(inst_valid), 32'd0);
    step(); #1;
    chk("t4_c5_valid", 32'(inst_valid), 32'd1);
    chk("t4_c5_pc", inst_pc, 32'h100);

    // Redirect to the top of the address space: PC wraps.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF; #1;
    chk("t5_redirect_blocks_inst", 32'(inst_valid), 32'd0);
    step(); redirect_valid = 1'b0; #1;
    chk("t5_addr_top", imem_req_addr, 32'hFFFF_FFFF);
    step(); #1;
    chk("t5_addr_wrap", imem_req_addr, 32'h0);
    step(); #1;
    chk("t5_pc_top", inst_pc, 32'hFFFF_FFFF);
    chk("t5_pc1_top", inst_pc_plus_1, 32'h0);
    chk("t5_inst_top", inst, 32'h0);
    step(); #1;
    chk("t5_pc_wrap", inst_pc, 32'h0);
    chk("t5_pc1_wrap", inst_pc_plus_1, 32'h1);

    // Reset with two queued entries and one outstanding fetch.
    redirect_valid = 1'b1; redirect_pc = 32'h200; inst_ready = 1'b0;
    step(); redirect_valid = 1'b0; #1;
    chk("t6_d1_addr", imem_req_addr, 32'h200);
    step(); step(); step(); #1;
    chk("t6_d4_valid", 32'(inst_valid), 32'd1);
    chk("t6_d4_pc", inst_pc, 32'h200);
    chk("t6_d4_addr", imem_req_addr, 32'h203);
    reset = 1'b1; #1;
    chk("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("t6_rst_inst_valid", 32'(inst_valid), 32'd0);
    step(); reset = 1'b0; inst_ready = 1'b1; #1;
    chk("t6_d5_inst_valid", 32'(inst_valid), 32'd0);
    chk("t6_d5_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t6_d5_addr", imem_req_addr, 32'd0);
    step(); #1;
    chk("t6_d6_inst_valid", 32'(inst_valid), 32'd0);
    step(); #1;
    chk("t6_d7_valid", 32'(inst_valid), 32'd1);
    chk("t6_d7_pc", inst_pc, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
